conv_feed_ctrl: RTL and testbench
=================================

// Module: conv_feed_ctrl
// PURPOSE
//  Stimulus sequencer/transmitter for the ConvCore multi-channel conv core. On start it streams
//  NUM_CHANNELS*9 weights from a synchronous weight RAM onto din1 (9 per channel, channel 0 first),
//  then forwards cfg_num_windows*9 activation samples from a valid/ready source onto the shared din0.
//  Drives core_en and a per-job latched sum_en. Sits between the layer scheduler and the conv core.
// PARAMETERS
//  INWIDTH       16  data width of weights/activations (signed, Q(INWIDTH-IN_FRAC).IN_FRAC)
//  NUM_CHANNELS  15  channels in the downstream core (15 or 45); weight count = NUM_CHANNELS*9
//  WINWIDTH      16  width of cfg_num_windows
//  AW            $clog2(NUM_CHANNELS*9)  weight RAM address width (derived, not overridden)
// PORTS
//  clk              in   1         rising-edge clock
//  reset            in   1         asynchronous, active-high reset
//  start            in   1         one-cycle job request; ignored unless busy==0
//  cfg_num_windows  in   WINWIDTH  windows per job (9 activations each); sampled on accepted start
//  cfg_sum_en       in   1         channel-sum mode for the job; sampled on accepted start
//  cfg_skip_w       in   1         1: reuse weights already in core, skip LOAD_W; sampled on start
//  w_rd             out  1         weight RAM read strobe
//  w_addr           out  AW        weight RAM address
//  w_data           in   INWIDTH   weight RAM data, valid exactly 1 cycle after w_rd
//  act_data         in   INWIDTH   activation sample
//  act_valid        in   1         activation sample valid
//  act_ready        out  1         activation accept; transfer on act_valid&&act_ready
//  core_full        in   1         downstream output FIFO full (used only with CONV_FEED_STALL_EN)
//  core_en          out  1         clock-enable to conv core
//  din0             out  INWIDTH   activation to core (registered)
//  din0_valid       out  1         activation valid
//  din1             out  INWIDTH   weight to core (= w_data, combinational)
//  din1_valid       out  1         weight valid (= w_rd delayed 1 cycle)
//  sum_en           out  1         latched cfg_sum_en, constant for the whole job
//  busy             out  1         high from accepted start until DONE exits
//  done             out  1         one-cycle pulse at job end
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; w_rd,w_addr,act_ready,din0,din0_valid,din1_valid,
//    sum_en,busy,done=0; core_en=1; counters=0. Reset mid-job abandons the job, no done pulse.
//  - FSM: IDLE -> (start) LOAD_W | STREAM_X | DONE; LOAD_W -> DRAIN_W -> STREAM_X | DONE;
//    STREAM_X -> DONE; DONE -> IDLE. start in IDLE: latch cfg_*, busy<=1 same edge.
//    Target after start: cfg_skip_w==0 -> LOAD_W; else cfg_num_windows!=0 -> STREAM_X; else DONE.
//  - LOAD_W: w_rd=1 every cycle, w_addr=0..NUM_CHANNELS*9-1 incrementing; after final address
//    go to DRAIN_W (1 cycle, w_rd=0) so last din1_valid is emitted. din1_valid count per job
//    exactly NUM_CHANNELS*9, contiguous, first one cycle after entering LOAD_W.
//  - DRAIN_W exit: cfg_num_windows==0 -> DONE, else STREAM_X.
//  - STREAM_X: act_ready=1 (subject to stall). Each transfer: din0<=act_data, din0_valid<=1 next
//    cycle; otherwise din0_valid<=0, din0 holds. Sample counter wraps 0..8 and increments window
//    counter on wrap; transfer of sample 9*cfg_num_windows-1 -> DONE, act_ready drops same edge.
//  - DONE: done=1 for exactly one cycle, busy<=0 on exit; sum_en held until next accepted start.
//  - din0_valid and din1_valid are never high in the same cycle. start while busy: no effect.
//  - Latency: act transfer -> din0_valid 1 cycle; w_rd -> din1_valid 1 cycle.
//  - act_valid outside STREAM_X is never accepted (act_ready=0).
// CONFIGURATION
//  CONV_FEED_STALL_EN defined: while core_full==1, core_en=0, w_rd=0, act_ready=0, all FSM state
//    and counters frozen; din0_valid/din1_valid hold their values (core ignores them, en low).
//    A w_rd issued in the cycle before stall still returns data: held in a 1-entry skid register
//    and presented on din1 on resume.
//  Not defined: core_full ignored, core_en tied 1, no skid register.
// TESTING
//  1 reset, start NUM_CHANNELS=15, cfg_num_windows=2, skip_w=0 -> 135 din1_valid pulses addr 0..134
//    data matches RAM, then 18 din0_valid, done pulse once, busy low after.
//  2 cfg_skip_w=1, cfg_num_windows=1, act_valid toggling 1/0 -> exactly 9 transfers, no w_rd, done.
//  3 cfg_num_windows=0, skip_w=1 -> start..done in 2 cycles, no din0/din1 valids.
//  4 start pulsed during STREAM_X with cfg_sum_en flipped -> ignored; sum_en unchanged until done.
//  5 async reset asserted mid LOAD_W (addr 50) -> all outputs to reset values immediately, no done.
//  6 (CONV_FEED_STALL_EN) core_full high 5 cycles at addr 70 -> core_en=0, no addr skipped/duplicated,
//    135 weights total in order.

Source files
------------

// File: rtl/conv_feed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// conv_feed_ctrl : streams weights (din1) then activations (din0) into ConvCore.
// Optional core back-pressure with weight skid register: CONV_FEED_STALL_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module conv_feed_ctrl #(
  parameter int INWIDTH      = 16,
  parameter int NUM_CHANNELS = 15,
  parameter int WINWIDTH     = 16,
  localparam int AW          = $clog2(NUM_CHANNELS*9)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [WINWIDTH-1:0] cfg_num_windows_i,
  input  logic                cfg_sum_en_i,
  input  logic                cfg_skip_w_i,
  output logic                w_rd_o,
  output logic [AW-1:0]       w_addr_o,
  input  logic [INWIDTH-1:0]  w_data_i,
  input  logic [INWIDTH-1:0]  act_data_i,
  input  logic                act_valid_i,
  output logic                act_ready_o,
  input  logic                core_full_i,
  output logic                core_en_o,
  output logic [INWIDTH-1:0]  din0_o,
  output logic                din0_valid_o,
  output logic [INWIDTH-1:0]  din1_o,
  output logic                din1_valid_o,
  output logic                sum_en_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int            NW        = NUM_CHANNELS * 9;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NW - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_W   = 3'd1;
  localparam logic [2:0] S_DRAIN_W  = 3'd2;
  localparam logic [2:0] S_STREAM_X = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [3:0]          samp_q, samp_d;
  logic [WINWIDTH-1:0] win_q, win_d;
  logic [WINWIDTH-1:0] nwin_q, nwin_d;
  logic                sum_en_q, sum_en_d;
  logic                busy_q, busy_d;
  logic [INWIDTH-1:0]  din0_q, din0_d;
  logic                din0_vld_q, din0_vld_d;
  logic                din1_vld_q, din1_vld_d;
  logic                stall;
  logic                xfer;

`ifdef CONV_FEED_STALL_EN
  logic [INWIDTH-1:0] skid_q;
  logic               skid_vld_q;

  assign stall = core_full_i;

  // Weight read in flight when the stall hits must survive until resume.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else if (stall && din1_vld_q && !skid_vld_q) begin
      skid_q     <= w_data_i;
      skid_vld_q <= 1'b1;
    end else if (!stall) begin
      skid_vld_q <= 1'b0;
    end
  end

  assign din1_o = skid_vld_q ? skid_q : w_data_i;
`else
  logic unused_core_full;

  assign unused_core_full = core_full_i;
  assign stall            = 1'b0;
  assign din1_o           = w_data_i;
`endif

  assign w_rd_o       = (state_q == S_LOAD_W) && !stall;
  assign act_ready_o  = (state_q == S_STREAM_X) && !stall;
  assign xfer         = act_valid_i && act_ready_o;
  assign done_o       = (state_q == S_DONE) && !stall;
  assign core_en_o    = !stall;
  assign w_addr_o     = addr_q;
  assign din0_o       = din0_q;
  assign din0_valid_o = din0_vld_q;
  assign din1_valid_o = din1_vld_q;
  assign sum_en_o     = sum_en_q;
  assign busy_o       = busy_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    samp_d     = samp_q;
    win_d      = win_q;
    nwin_d     = nwin_q;
    sum_en_d   = sum_en_q;
    busy_d     = busy_q;
    din0_d     = din0_q;
    din0_vld_d = din0_vld_q;
    din1_vld_d = din1_vld_q;
    if (!stall) begin
      din1_vld_d = w_rd_o;
      din0_vld_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            nwin_d   = cfg_num_windows_i;
            sum_en_d = cfg_sum_en_i;
            busy_d   = 1'b1;
            addr_d   = '0;
            samp_d   = '0;
            win_d    = '0;
            if (!cfg_skip_w_i)                state_d = S_LOAD_W;
            else if (cfg_num_windows_i != '0) state_d = S_STREAM_X;
            else                              state_d = S_DONE;
          end
        end
        S_LOAD_W: begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_DRAIN_W;
          end else begin
            addr_d  = addr_q + 1'b1;
          end
        end
        S_DRAIN_W: state_d = (nwin_q == '0) ? S_DONE : S_STREAM_X;
        S_STREAM_X: begin
          if (xfer) begin
            din0_d     = act_data_i;
            din0_vld_d = 1'b1;
            if (samp_q == 4'd8) begin
              samp_d = '0;
              win_d  = win_q + WINWIDTH'(1);
              if (win_q == nwin_q - WINWIDTH'(1)) state_d = S_DONE;
            end else begin
              samp_d = samp_q + 4'd1;
            end
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      samp_q     <= '0;
      win_q      <= '0;
      nwin_q     <= '0;
      sum_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      din0_q     <= '0;
      din0_vld_q <= 1'b0;
      din1_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      samp_q     <= samp_d;
      win_q      <= win_d;
      nwin_q     <= nwin_d;
      sum_en_q   <= sum_en_d;
      busy_q     <= busy_d;
      din0_q     <= din0_d;
      din0_vld_q <= din0_vld_d;
      din1_vld_q <= din1_vld_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_feed_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_conv_feed_ctrl : scoreboard bench for conv_feed_ctrl (15 channels).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_conv_feed_ctrl;

  localparam int NW = 15 * 9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_num_windows = '0;
  logic        cfg_sum_en = 1'b0;
  logic        cfg_skip_w = 1'b0;
  logic        w_rd;
  logic [7:0]  w_addr;
  logic [15:0] w_data = '0;
  logic [15:0] act_data = '0;
  logic        act_valid = 1'b0;
  logic        act_ready;
  logic        core_full = 1'b0;
  logic        core_en;
  logic [15:0] din0;
  logic        din0_valid;
  logic [15:0] din1;
  logic        din1_valid;
  logic        sum_en;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int n_w = 0, n_x = 0, n_rd = 0, n_done = 0;
  int exp_addr = 0;
  int act_mode = 0;
  logic [15:0] wq[$];
  logic [15:0] xq[$];
  logic [15:0] mem [NW];

  conv_feed_ctrl #(.INWIDTH(16), .NUM_CHANNELS(15), .WINWIDTH(16)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .cfg_num_windows_i(cfg_num_windows), .cfg_sum_en_i(cfg_sum_en), .cfg_skip_w_i(cfg_skip_w),
    .w_rd_o(w_rd), .w_addr_o(w_addr), .w_data_i(w_data),
    .act_data_i(act_data), .act_valid_i(act_valid), .act_ready_o(act_ready),
    .core_full_i(core_full), .core_en_o(core_en),
    .din0_o(din0), .din0_valid_o(din0_valid), .din1_o(din1), .din1_valid_o(din1_valid),
    .sum_en_o(sum_en), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Synchronous weight RAM, data one cycle after the read strobe.
  always @(posedge clk) if (w_rd) w_data <= mem[w_addr];

  // Activation source.
  always @(posedge clk) begin
    #1;
    case (act_mode)
      1:       act_valid = 1'b1;
      2:       act_valid = ~act_valid;
      default: act_valid = 1'b0;
    endcase
    act_data = 16'($urandom);
  end

  // Scoreboard monitor: judged just before the edge that consumes the outputs.
  always @(negedge clk) begin
    if (!reset) begin
      if (din0_valid && din1_valid) begin
        checks++; failures++;
        $display("FAIL overlap: din0_valid=%b din1_valid=%b, required not both", din0_valid, din1_valid);
      end
      if (core_en && din1_valid) begin
        n_w++; checks++;
        if (wq.size() == 0) begin
          failures++; $display("FAIL din1_extra: din1=%h with empty weight queue", din1);
        end else begin
          logic [15:0] e;
          e = wq.pop_front();
          if (din1 !== e) begin
            failures++; $display("FAIL din1_data: got %h required %h", din1, e);
          end
        end
      end
      if (core_en && din0_valid) begin
        n_x++; checks++;
        if (xq.size() == 0) begin
          failures++; $display("FAIL din0_extra: din0=%h with empty activation queue", din0);
        end else begin
          logic [15:0] e;
          e = xq.pop_front();
          if (din0 !== e) begin
            failures++; $display("FAIL din0_data: got %h required %h", din0, e);
          end
        end
      end
      if (w_rd) begin
        n_rd++; checks++;
        if (w_addr !== 8'(exp_addr)) begin
          failures++; $display("FAIL w_addr: got %0d required %0d", w_addr, exp_addr);
        end
        exp_addr = (exp_addr == NW - 1) ? 0 : exp_addr + 1;
      end
      if (act_valid && act_ready) xq.push_back(act_data);
      if (done) n_done++;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_weights();
    for (int i = 0; i < NW; i++) wq.push_back(mem[i]);
  endtask

  task automatic pulse_start(input logic [15:0] nw, input logic se, input logic sk);
    cfg_num_windows = nw; cfg_sum_en = se; cfg_skip_w = sk; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; #3;
    checks++;
    if ({w_rd, act_ready, din0_valid, din1_valid, sum_en, busy, done} !== 7'b0 ||
        w_addr !== 8'd0 || din0 !== 16'd0 || core_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: rd=%b rdy=%b v0=%b v1=%b se=%b busy=%b done=%b addr=%0d din0=%h en=%b, required zeros and en=1",
               w_rd, act_ready, din0_valid, din1_valid, sum_en, busy, done, w_addr, din0, core_en);
    end
    repeat (2) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || act_ready !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b act_ready=%b required 0 0", busy, act_ready);
    end
  endtask

  task automatic test_weights_and_stream();
    int w0, x0, r0, d0;
    w0 = n_w; x0 = n_x; r0 = n_rd; d0 = n_done;
    push_weights();
    act_mode = 1;
    pulse_start(16'd2, 1'b1, 1'b0);
    checks++;
    if (busy !== 1'b1 || act_ready !== 1'b0) begin
      failures++; $display("FAIL load_start: busy=%b act_ready=%b required 1 0", busy, act_ready);
    end
    for (int i = 0; i < 600 && n_done == d0; i++) tick();
    checks++;
    if (n_rd - r0 != NW || n_w - w0 != NW) begin
      failures++; $display("FAIL weight_count: rd=%0d din1=%0d required %0d", n_rd - r0, n_w - w0, NW);
    end
    checks++;
    if (n_x - x0 != 18 || xq.size() != 0 || wq.size() != 0) begin
      failures++; $display("FAIL act_count: din0=%0d xq=%0d wq=%0d required 18 0 0", n_x - x0, xq.size(), wq.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL busy_after_done: got %b required 0", busy);
    end
    act_mode = 0;
    repeat (3) tick();
    checks++;
    if (n_done - d0 != 1 || sum_en !== 1'b1) begin
      failures++; $display("FAIL done_once: pulses=%0d sum_en=%b required 1 1", n_done - d0, sum_en);
    end
  endtask

  task automatic test_skip_toggle();
    int w0, x0, r0, d0;
    w0 = n_w; x0 = n_x; r0 = n_rd; d0 = n_done;
    act_mode = 2;
    repeat (2) tick();
    checks++;
    if (act_ready !== 1'b0) begin
      failures++; $display("FAIL idle_ready: got %b required 0", act_ready);
    end
    pulse_start(16'd1, 1'b0, 1'b1);
    for (int i = 0; i < 100 && n_done == d0; i++) tick();
    act_mode = 0;
    repeat (2) tick();
    checks++;
    if (n_x - x0 != 9 || n_rd != r0 || n_w != w0 || n_done - d0 != 1 || xq.size() != 0) begin
      failures++;
      $display("FAIL skip_toggle: din0=%0d rd=%0d din1=%0d done=%0d xq=%0d required 9 0 0 1 0",
               n_x - x0, n_rd - r0, n_w - w0, n_done - d0, xq.size());
    end
  endtask

  task automatic test_zero_windows();
    int w0, x0;
    w0 = n_w; x0 = n_x;
    pulse_start(16'd0, 1'b0, 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL zero_done: done=%b busy=%b required 1 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || n_w != w0 || n_x != x0) begin
      failures++; $display("FAIL zero_end: done=%b busy=%b din1=%0d din0=%0d required 0 0 0 0",
                           done, busy, n_w - w0, n_x - x0);
    end
  endtask

  task automatic test_start_while_busy();
    int x0, r0, d0, bad;
    x0 = n_x; r0 = n_rd; d0 = n_done; bad = 0;
    act_mode = 1;
    pulse_start(16'd2, 1'b0, 1'b1);
    for (int i = 0; i < 10 && act_ready !== 1'b1; i++) tick();
    repeat (3) tick();
    pulse_start(16'd5, 1'b1, 1'b0);
    for (int i = 0; i < 100 && n_done == d0; i++) begin
      if (sum_en !== 1'b0) bad++;
      tick();
    end
    act_mode = 0;
    repeat (3) tick();
    checks++;
    if (bad != 0 || sum_en !== 1'b0) begin
      failures++; $display("FAIL sum_en_hold: changed %0d cycles, sum_en=%b required 0", bad, sum_en);
    end
    checks++;
    if (n_x - x0 != 18 || n_rd != r0 || n_done - d0 != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL busy_start_ignored: din0=%0d rd=%0d done=%0d busy=%b required 18 0 1 0",
                           n_x - x0, n_rd - r0, n_done - d0, busy);
    end
  endtask

  task automatic test_reset_mid_load();
    int d0;
    d0 = n_done;
    push_weights();
    pulse_start(16'd1, 1'b1, 1'b0);
    for (int i = 0; i < 100 && !(w_rd === 1'b1 && w_addr == 8'd50); i++) tick();
    checks++;
    if (w_addr !== 8'd50 || w_rd !== 1'b1) begin
      failures++; $display("FAIL reach_addr50: addr=%0d w_rd=%b required 50 1", w_addr, w_rd);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({w_rd, act_ready, din0_valid, din1_valid, sum_en, busy, done} !== 7'b0 ||
        w_addr !== 8'd0 || core_en !== 1'b1) begin
      failures++; $display("FAIL async_reset: rd=%b rdy=%b v0=%b v1=%b se=%b busy=%b done=%b addr=%0d en=%b",
                           w_rd, act_ready, din0_valid, din1_valid, sum_en, busy, done, w_addr, core_en);
    end
    tick();
    wq.delete(); xq.delete(); exp_addr = 0;
    reset = 1'b0;
    repeat (10) tick();
    checks++;
    if (n_done != d0 || busy !== 1'b0 || w_rd !== 1'b0) begin
      failures++; $display("FAIL reset_abandon: done=%0d busy=%b w_rd=%b required 0 0 0", n_done - d0, busy, w_rd);
    end
  endtask

`ifdef CONV_FEED_STALL_EN
  task automatic test_stall();
    int w0, r0, d0, bad;
    w0 = n_w; r0 = n_rd; d0 = n_done; bad = 0;
    push_weights();
    pulse_start(16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !(w_rd === 1'b1 && w_addr == 8'd70); i++) tick();
    core_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (core_en !== 1'b0 || w_rd !== 1'b0) bad++;
      if (k < 4) tick();
    end
    tick();
    core_full = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL stall_outputs: %0d stalled cycles with core_en or w_rd high, required 0", bad);
    end
    for (int i = 0; i < 400 && n_done == d0; i++) tick();
    checks++;
    if (n_w - w0 != NW || n_rd - r0 != NW || wq.size() != 0) begin
      failures++; $display("FAIL stall_weights: din1=%0d rd=%0d wq=%0d required %0d %0d 0",
                           n_w - w0, n_rd - r0, wq.size(), NW, NW);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 16'(i * 16'h0123) ^ 16'h5A5A;
    test_reset();
    test_weights_and_stream();
    test_skip_toggle();
    test_zero_windows();
    test_start_while_busy();
    test_reset_mid_load();
`ifdef CONV_FEED_STALL_EN
    test_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
